// File: rtl/pipe_rx_ts_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcie_os_pkg
// Brief    : Ordered-set symbol codes, PIPE status codes, decoder state and
//            TS field record shared by the lane receive decoder.
// Revision : 1.0
// ============================================================================
package pcie_os_pkg;

    localparam logic [7:0] C_COM    = 8'hBC;
    localparam logic [7:0] C_PAD    = 8'hF7;
    localparam logic [7:0] C_IDL    = 8'h7C;
    localparam logic [7:0] C_SKP    = 8'h1C;
    localparam logic [7:0] C_TS1_ID = 8'h4A;
    localparam logic [7:0] C_TS2_ID = 8'h45;

    localparam logic [2:0] C_ST_DECODE_ERR = 3'b100;
    localparam logic [2:0] C_ST_DISP_ERR   = 3'b111;

    typedef enum logic [1:0] {
        S_HUNT   = 2'd0,
        S_FIELDS = 2'd1,
        S_IDENT  = 2'd2,
        S_EIOS   = 2'd3
    } os_state_e;

    typedef struct packed {
        logic       ts_type;
        logic [7:0] link_num;
        logic       link_pad;
        logic [7:0] lane_num;
        logic       lane_pad;
        logic [7:0] n_fts;
        logic [7:0] rate_id;
        logic [7:0] train_ctrl;
    } ts_fields_t;

    function automatic logic is_bad_status(input logic [2:0] status);
        return (status == C_ST_DECODE_ERR) || (status == C_ST_DISP_ERR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_rx_ts_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_rx_ts_decoder_if
// Brief    : One lane of PIPE RX symbols in, decoded TS/EIOS events out.
// Revision : 1.0
// ============================================================================
interface pipe_rx_ts_decoder_if #(
    parameter int CNT_WIDTH = 4
);
    logic [7:0]           RxData;
    logic                 RxDataK;
    logic                 RxValid;
    logic [2:0]           RxStatus;
    logic                 clear_cnt;

    logic                 ts_valid;
    logic                 ts_type;
    logic [7:0]           link_num;
    logic                 link_pad;
    logic [7:0]           lane_num;
    logic                 lane_pad;
    logic [7:0]           n_fts;
    logic [7:0]           rate_id;
    logic [7:0]           train_ctrl;
    logic [CNT_WIDTH-1:0] consec_cnt;
    logic                 eios_det;
    logic                 os_err;

    modport master (
        output RxData, RxDataK, RxValid, RxStatus, clear_cnt,
        input  ts_valid, ts_type, link_num, link_pad, lane_num, lane_pad,
               n_fts, rate_id, train_ctrl, consec_cnt, eios_det, os_err
    );

    modport slave (
        input  RxData, RxDataK, RxValid, RxStatus, clear_cnt,
        output ts_valid, ts_type, link_num, link_pad, lane_num, lane_pad,
               n_fts, rate_id, train_ctrl, consec_cnt, eios_det, os_err
    );
endinterface
`default_nettype wire

// File: rtl/pipe_rx_ts_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pipe_rx_ts_decoder
// Brief    : Per-lane Gen1/Gen2 TS1/TS2/EIOS decoder with consecutive-TS count.
// Revision : 1.0
// ============================================================================
module pipe_rx_ts_decoder
    import pcie_os_pkg::*;
#(
    parameter int CNT_WIDTH = 4
) (
    input  wire logic           CLK,
    input  wire logic           reset,
    pipe_rx_ts_decoder_if.slave rx
);

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] C_CNT_ONE = CNT_WIDTH'(1);

    os_state_e            state_q, state_d;
    logic [3:0]           sym_idx_q, sym_idx_d;
    logic [7:0]           ident_q, ident_d;
    ts_fields_t           rx_fields_q, rx_fields_d;
    // Last good TS: drives the field outputs and is the reference for the repeat compare.
    ts_fields_t           out_fields_q, out_fields_d;
    logic                 ts_valid_q, ts_valid_d;
    logic                 eios_det_q, eios_det_d;
    logic                 os_err_q, os_err_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic       w_sym_ok;
    logic       w_sym_bad;
    logic       w_is_k;
    logic       w_is_com;
    logic [7:0] w_data;
    logic       w_abort;
    logic       w_done;
    ts_fields_t w_new_ts;

    assign w_data    = rx.RxData;
    assign w_is_k    = rx.RxDataK;
    assign w_sym_ok  = rx.RxValid && !is_bad_status(rx.RxStatus);
    assign w_sym_bad = rx.RxValid &&  is_bad_status(rx.RxStatus);
    assign w_is_com  = w_is_k && (w_data == C_COM);

    always_comb begin
        state_d      = state_q;
        sym_idx_d    = sym_idx_q;
        ident_d      = ident_q;
        rx_fields_d  = rx_fields_q;
        out_fields_d = out_fields_q;
        ts_valid_d   = 1'b0;
        eios_det_d   = 1'b0;
        os_err_d     = 1'b0;
        cnt_d        = cnt_q;
        w_abort      = 1'b0;
        w_done       = 1'b0;
        w_new_ts         = rx_fields_q;
        w_new_ts.ts_type = (ident_q == C_TS2_ID);

        if (w_sym_bad && (state_q != S_HUNT)) begin
            w_abort = 1'b1;
        end else if (w_sym_ok) begin
            case (state_q)
                S_HUNT: begin
                    if (w_is_com) begin
                        state_d   = S_FIELDS;
                        sym_idx_d = 4'd1;
                    end
                end
                S_FIELDS: begin
                    if (sym_idx_q == 4'd1) begin
                        if (w_is_k && (w_data == C_SKP)) begin
                            state_d   = S_HUNT;
                            sym_idx_d = 4'd0;
                        end else if (w_is_k && (w_data == C_IDL)) begin
                            state_d   = S_EIOS;
                            sym_idx_d = 4'd1;
                        end else if (!w_is_k || (w_data == C_PAD)) begin
                            rx_fields_d.link_num = w_data;
                            rx_fields_d.link_pad = w_is_k;
                            sym_idx_d            = 4'd2;
                        end else begin
                            w_abort = 1'b1;
                        end
                    end else if (sym_idx_q == 4'd2) begin
                        if (!w_is_k || (w_data == C_PAD)) begin
                            rx_fields_d.lane_num = w_data;
                            rx_fields_d.lane_pad = w_is_k;
                            sym_idx_d            = 4'd3;
                        end else begin
                            w_abort = 1'b1;
                        end
                    end else if (!w_is_k) begin
                        if (sym_idx_q == 4'd3) begin
                            rx_fields_d.n_fts = w_data;
                        end else if (sym_idx_q == 4'd4) begin
                            rx_fields_d.rate_id = w_data;
                        end else begin
                            rx_fields_d.train_ctrl = w_data;
                            state_d                = S_IDENT;
                        end
                        sym_idx_d = sym_idx_q + 4'd1;
                    end else begin
                        w_abort = 1'b1;
                    end
                end
                S_IDENT: begin
                    // Symbol 6 picks the identifier; 7..15 must repeat it exactly.
                    if (!w_is_k &&
                        (((sym_idx_q == 4'd6) && ((w_data == C_TS1_ID) || (w_data == C_TS2_ID))) ||
                         ((sym_idx_q != 4'd6) && (w_data == ident_q)))) begin
                        if (sym_idx_q == 4'd6) begin
                            ident_d = w_data;
                        end
                        if (sym_idx_q == 4'd15) begin
                            w_done    = 1'b1;
                            state_d   = S_HUNT;
                            sym_idx_d = 4'd0;
                        end else begin
                            sym_idx_d = sym_idx_q + 4'd1;
                        end
                    end else begin
                        w_abort = 1'b1;
                    end
                end
                S_EIOS: begin
                    if (w_is_k && (w_data == C_IDL)) begin
                        if (sym_idx_q == 4'd2) begin
                            eios_det_d = 1'b1;
                            state_d    = S_HUNT;
                            sym_idx_d  = 4'd0;
                        end else begin
                            sym_idx_d = sym_idx_q + 4'd1;
                        end
                    end else begin
                        w_abort = 1'b1;
                    end
                end
                default: begin
                    state_d   = S_HUNT;
                    sym_idx_d = 4'd0;
                end
            endcase
        end

        if (w_abort) begin
            os_err_d = 1'b1;
            // A COM that breaks an ordered set is itself the start of the next one.
            if (w_sym_ok && w_is_com) begin
                state_d   = S_FIELDS;
                sym_idx_d = 4'd1;
            end else begin
                state_d   = S_HUNT;
                sym_idx_d = 4'd0;
            end
        end

        if (w_done) begin
            ts_valid_d   = 1'b1;
            out_fields_d = w_new_ts;
            if (!rx.clear_cnt && (w_new_ts == out_fields_q) && (cnt_q != '0)) begin
                cnt_d = (cnt_q == C_CNT_MAX) ? cnt_q : (cnt_q + C_CNT_ONE);
            end else begin
                cnt_d = C_CNT_ONE;
            end
        end else if (w_abort || rx.clear_cnt) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q      <= S_HUNT;
            sym_idx_q    <= 4'd0;
            ident_q      <= 8'd0;
            rx_fields_q  <= '0;
            out_fields_q <= '0;
            ts_valid_q   <= 1'b0;
            eios_det_q   <= 1'b0;
            os_err_q     <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            sym_idx_q    <= sym_idx_d;
            ident_q      <= ident_d;
            rx_fields_q  <= rx_fields_d;
            out_fields_q <= out_fields_d;
            ts_valid_q   <= ts_valid_d;
            eios_det_q   <= eios_det_d;
            os_err_q     <= os_err_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rx.ts_valid   = ts_valid_q;
    assign rx.eios_det   = eios_det_q;
    assign rx.os_err     = os_err_q;
    assign rx.consec_cnt = cnt_q;
    assign rx.ts_type    = out_fields_q.ts_type;
    assign rx.link_num   = out_fields_q.link_num;
    assign rx.link_pad   = out_fields_q.link_pad;
    assign rx.lane_num   = out_fields_q.lane_num;
    assign rx.lane_pad   = out_fields_q.lane_pad;
    assign rx.n_fts      = out_fields_q.n_fts;
    assign rx.rate_id    = out_fields_q.rate_id;
    assign rx.train_ctrl = out_fields_q.train_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_pipe_rx_ts_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_rx_ts_decoder
// Brief    : Randomized ordered-set stimulus with a queue-based scoreboard.
// Revision : 1.0
// ============================================================================
module tb_pipe_rx_ts_decoder;

    localparam int CNT_WIDTH = 4;
    localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;
    localparam int K_TS = 0, K_EIOS = 1, K_ERR = 2;

    localparam logic [7:0] COM = 8'hBC, PAD = 8'hF7, IDL = 8'h7C, SKP = 8'h1C;
    localparam logic [7:0] TS1 = 8'h4A, TS2 = 8'h45;
    localparam logic [2:0] ST_DEC = 3'b100, ST_DISP = 3'b111;

    typedef struct {
        int          kind;
        logic [42:0] f;
        int          cnt;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [42:0] last_good;
    int          mcnt;
    int          gap_at;

    pipe_rx_ts_decoder_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();
    pipe_rx_ts_decoder #(.CNT_WIDTH(CNT_WIDTH)) dut (.CLK(CLK), .reset(reset), .rx(bus));

    always #5 CLK = ~CLK;

    function automatic logic [42:0] mk_fields(input logic t, input logic [7:0] ln, input logic lp,
                                              input logic [7:0] la, input logic ap, input logic [7:0] nf,
                                              input logic [7:0] rt, input logic [7:0] tc);
        return {t, ln, lp, la, ap, nf, rt, tc};
    endfunction

    function automatic logic [42:0] rand_fields();
        logic lp, ap;
        lp = ($urandom_range(3) == 0);
        ap = ($urandom_range(3) == 0);
        return mk_fields(1'($urandom_range(1)), lp ? PAD : 8'($urandom), lp,
                         ap ? PAD : 8'($urandom), ap, 8'($urandom), 8'($urandom), 8'($urandom));
    endfunction

    function automatic logic [42:0] dut_fields();
        return {bus.ts_type, bus.link_num, bus.link_pad, bus.lane_num, bus.lane_pad,
                bus.n_fts, bus.rate_id, bus.train_ctrl};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a good TS repeats the count only if it equals the previous good TS.
    task automatic expect_ts(input logic [42:0] f, input bit clr);
        int n;
        if (clr) n = 1;
        else if (mcnt != 0 && f == last_good) n = (mcnt >= CNT_MAX) ? CNT_MAX : mcnt + 1;
        else n = 1;
        mcnt      = n;
        last_good = f;
        exp_q.push_back('{K_TS, f, n});
    endtask

    task automatic expect_err();
        mcnt = 0;
        exp_q.push_back('{K_ERR, last_good, 0});
    endtask

    task automatic expect_eios();
        exp_q.push_back('{K_EIOS, last_good, mcnt});
    endtask

    task automatic drive(input logic k, input logic [7:0] d, input logic [2:0] st,
                         input logic clr, input int gaps);
        int g = gaps;
        if (g == 0 && $urandom_range(9) == 0) g = $urandom_range(1, 3);
        repeat (g) begin
            bus.RxValid   = 1'b0;
            bus.RxDataK   = 1'($urandom_range(1));
            bus.RxData    = ($urandom_range(1) != 0) ? COM : 8'($urandom);
            bus.RxStatus  = 3'($urandom_range(7));
            bus.clear_cnt = 1'b0;
            @(posedge CLK); #1;
        end
        bus.RxValid   = 1'b1;
        bus.RxDataK   = k;
        bus.RxData    = d;
        bus.RxStatus  = st;
        bus.clear_cnt = clr;
        @(posedge CLK); #1;
        bus.RxValid   = 1'b0;
        bus.clear_cnt = 1'b0;
    endtask

    // bad_kind: 1 = status error, 2 = COM (restart, caller sends the body), 3 = wrong symbol
    task automatic send_ts(input logic [42:0] f, input int bad_pos, input int bad_kind,
                           input bit clr, input bit with_com);
        logic [7:0] ident, other;
        logic       ks [16];
        logic [7:0] ds [16];
        ident = f[42] ? TS2 : TS1;
        other = f[42] ? TS1 : TS2;
        ks[0] = 1'b1;     ds[0] = COM;
        ks[1] = f[33];    ds[1] = f[41:34];
        ks[2] = f[24];    ds[2] = f[32:25];
        ks[3] = 1'b0;     ds[3] = f[23:16];
        ks[4] = 1'b0;     ds[4] = f[15:8];
        ks[5] = 1'b0;     ds[5] = f[7:0];
        for (int i = 6; i < 16; i++) begin
            ks[i] = 1'b0;
            ds[i] = ident;
        end
        for (int i = with_com ? 0 : 1; i < 16; i++) begin
            int g = (i == gap_at) ? 3 : 0;
            if (i == bad_pos) begin
                expect_err();
                case (bad_kind)
                    1: drive(ks[i], ds[i], ($urandom_range(1) != 0) ? ST_DISP : ST_DEC, 1'b0, g);
                    2: begin
                        drive(1'b1, COM, 3'b000, 1'b0, g);
                        return;
                    end
                    default: begin
                        if (i <= 5)
                            drive(1'b1, (i >= 3 && $urandom_range(1) != 0) ? PAD : 8'hFB, 3'b000, 1'b0, g);
                        else if (i == 6)
                            drive(1'b0, 8'h4B, 3'b000, 1'b0, g);
                        else if ($urandom_range(1) != 0)
                            drive(1'b1, ident, 3'b000, 1'b0, g);
                        else
                            drive(1'b0, other, 3'b000, 1'b0, g);
                    end
                endcase
            end else begin
                if (i == 15 && bad_pos < 0) expect_ts(f, clr);
                drive(ks[i], ds[i], 3'b000, (i == 15 && bad_pos < 0) ? clr : 1'b0, g);
            end
        end
    endtask

    task automatic send_eios(input int bad_pos, input int bad_kind);
        drive(1'b1, COM, 3'b000, 1'b0, 0);
        for (int i = 1; i < 4; i++) begin
            if (i == bad_pos) begin
                expect_err();
                case (bad_kind)
                    1: drive(1'b1, IDL, ST_DEC, 1'b0, 0);
                    2: begin
                        drive(1'b1, COM, 3'b000, 1'b0, 0);
                        return;
                    end
                    default: drive(1'b0, 8'($urandom), 3'b000, 1'b0, 0);
                endcase
            end else begin
                if (i == 3 && bad_pos < 0) expect_eios();
                drive(1'b1, IDL, 3'b000, 1'b0, 0);
            end
        end
    endtask

    task automatic send_skp();
        drive(1'b1, COM, 3'b000, 1'b0, 0);
        repeat (3) drive(1'b1, SKP, 3'b000, 1'b0, 0);
    endtask

    task automatic filler();
        repeat ($urandom_range(0, 3)) begin
            case ($urandom_range(0, 9))
                0: drive(1'b1, COM, ST_DEC, 1'b0, 0);
                1: begin
                    mcnt = 0;
                    drive(1'b0, 8'($urandom), 3'b000, 1'b1, 0);
                end
                default: drive(1'b0, 8'($urandom), 3'b000, 1'b0, 0);
            endcase
        end
    endtask

    always @(negedge CLK) begin
        if (bus.ts_valid === 1'b1 || bus.eios_det === 1'b1 || bus.os_err === 1'b1) begin
            check("pulse_exclusive", 64'($countones({bus.ts_valid, bus.eios_det, bus.os_err})), 64'd1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: got ts/eios/err=%b%b%b expected none at %0t",
                         bus.ts_valid, bus.eios_det, bus.os_err, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_kind", bus.ts_valid ? 64'(K_TS) : (bus.eios_det ? 64'(K_EIOS) : 64'(K_ERR)),
                      64'(mon_e.kind));
                check((mon_e.kind == K_TS) ? "ts_fields" : "held_fields", 64'(dut_fields()), 64'(mon_e.f));
                check("consec_cnt", 64'(bus.consec_cnt), 64'(mon_e.cnt));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [42:0] f1, f2, f3, rf;
        bus.RxValid   = 1'b0;
        bus.RxDataK   = 1'b0;
        bus.RxData    = 8'h00;
        bus.RxStatus  = 3'b000;
        bus.clear_cnt = 1'b0;
        reset     = 1'b1;
        gap_at    = -1;
        mcnt      = 0;
        last_good = '0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_outputs", 64'({dut_fields(), bus.consec_cnt, bus.ts_valid, bus.eios_det, bus.os_err}), 64'd0);
        reset = 1'b0;
        @(posedge CLK); #1;

        f1 = mk_fields(1'b0, 8'h05, 1'b0, 8'h02, 1'b0, 8'h20, 8'h02, 8'h00);
        f2 = mk_fields(1'b1, PAD, 1'b1, PAD, 1'b1, 8'h18, 8'h02, 8'h00);
        f3 = mk_fields(1'b0, 8'h07, 1'b0, 8'h01, 1'b0, 8'h40, 8'h06, 8'h08);

        send_ts(f1, -1, 0, 1'b0, 1'b1);
        send_ts(f1, -1, 0, 1'b0, 1'b1);
        repeat (20) send_ts(f2, -1, 0, 1'b0, 1'b1);
        send_ts(f1, 9, 3, 1'b0, 1'b1);
        send_ts(f1, -1, 0, 1'b0, 1'b1);
        send_eios(-1, 0);
        send_ts(f3, -1, 0, 1'b0, 1'b1);
        send_ts(f1, -1, 0, 1'b0, 1'b1);
        send_skp();
        send_ts(f1, -1, 0, 1'b0, 1'b1);
        send_ts(f1, 4, 1, 1'b0, 1'b1);
        gap_at = 10;
        send_ts(f1, -1, 0, 1'b0, 1'b1);
        gap_at = -1;
        send_ts(f1, 10, 2, 1'b0, 1'b1);
        send_ts(f1, -1, 0, 1'b0, 1'b0);
        send_ts(f1, -1, 0, 1'b1, 1'b1);

        for (int n = 0; n < 200; n++) begin
            int sel;
            int pos;
            int kind;
            sel = $urandom_range(0, 9);
            rf  = ($urandom_range(2) != 0) ? last_good : rand_fields();
            if (sel < 5) begin
                send_ts(rf, -1, 0, ($urandom_range(9) == 0), 1'b1);
            end else if (sel < 7) begin
                pos  = $urandom_range(1, 15);
                kind = $urandom_range(1, 3);
                send_ts(rf, pos, kind, 1'b0, 1'b1);
                if (kind == 2) send_ts(rf, -1, 0, 1'b0, 1'b0);
            end else if (sel == 7) begin
                send_eios(-1, 0);
            end else if (sel == 8) begin
                kind = $urandom_range(1, 3);
                send_eios($urandom_range(2, 3), kind);
                if (kind == 2) send_ts(rf, -1, 0, 1'b0, 1'b0);
            end else begin
                send_skp();
            end
            filler();
        end

        repeat (4) @(posedge CLK);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        drive(1'b1, COM, 3'b000, 1'b0, 0);
        repeat (5) drive(1'b0, 8'h11, 3'b000, 1'b0, 0);
        repeat (3) drive(1'b0, TS1, 3'b000, 1'b0, 0);
        reset = 1'b1;
        @(posedge CLK); #1;
        check("reset_mid_ts", 64'({dut_fields(), bus.consec_cnt, bus.ts_valid, bus.eios_det, bus.os_err}), 64'd0);
        reset     = 1'b0;
        mcnt      = 0;
        last_good = '0;
        repeat (7) drive(1'b0, TS1, 3'b000, 1'b0, 0);
        send_ts(f1, -1, 0, 1'b0, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        drive(1'b0, 8'h00, 3'b000, 1'b1, 0);
        check("clear_alone", 64'(bus.consec_cnt), 64'd0);
        repeat (3) @(posedge CLK);
        #1;
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
